// File: rtl/cordic_shift_accumulate.sv
// One registered micro-rotation stage of a rotation-mode CORDIC pipeline (Q10 angles).
// Optional macro CORDIC_SA_VALID_EN adds in_valid/out_valid and gates output loading.
module cordic_shift_accumulate #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
`ifdef CORDIC_SA_VALID_EN
  input  logic             in_valid,
  output logic             out_valid,
`endif
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] atanVal;
  logic             zNeg;
  logic             loadEn;

  logic [WIDTH-1:0] x_d, y_d, z_d;
  logic [WIDTH-1:0] x_q, y_q, z_q;

  // atan(2^-i) in Q10; entries beyond the table resolve to zero.
  always_comb begin
    atanVal = '0;
    case (i)
      IDX_W'(0):  atanVal = WIDTH'(804);
      IDX_W'(1):  atanVal = WIDTH'(474);
      IDX_W'(2):  atanVal = WIDTH'(250);
      IDX_W'(3):  atanVal = WIDTH'(127);
      IDX_W'(4):  atanVal = WIDTH'(63);
      IDX_W'(5):  atanVal = WIDTH'(31);
      IDX_W'(6):  atanVal = WIDTH'(15);
      IDX_W'(7):  atanVal = WIDTH'(7);
      IDX_W'(8):  atanVal = WIDTH'(3);
      IDX_W'(9):  atanVal = WIDTH'(1);
      default:    atanVal = '0;
    endcase
  end

  assign xs   = WIDTH'($signed(x) >>> i);
  assign ys   = WIDTH'($signed(y) >>> i);
  assign zNeg = z[WIDTH-1];

`ifdef CORDIC_SA_VALID_EN
  assign loadEn = in_valid;
`else
  assign loadEn = 1'b1;
`endif

  // Rotation direction follows the sign of the residual angle; zero counts as positive.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (loadEn) begin
      if (zNeg) begin
        x_d = x + ys;
        y_d = y - xs;
        z_d = z + atanVal;
      end else begin
        x_d = x - ys;
        y_d = y + xs;
        z_d = z - atanVal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

`ifdef CORDIC_SA_VALID_EN
  logic valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= in_valid;
  end

  assign out_valid = valid_q;
`endif

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule

// File: tb/tb_cordic_shift_accumulate.sv
// Scoreboard bench for cordic_shift_accumulate: directed spec vectors, random vectors
// against an arithmetic reference model, and asynchronous reset checks.
module tb_cordic_shift_accumulate;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i;
  logic [31:0] x, y, z;
  logic [31:0] x_out, y_out, z_out;
`ifdef CORDIC_SA_VALID_EN
  logic        in_valid;
  logic        out_valid;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cycle;
    int          tag;
    logic [31:0] ex;
    logic [31:0] ey;
    logic [31:0] ez;
  } expect_t;

  expect_t sbQueue[$];

  cordic_shift_accumulate #(.WIDTH(32), .IDX_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i        (i),
    .x        (x),
    .y        (y),
    .z        (z),
`ifdef CORDIC_SA_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: floor division by 2^s stands in for the arithmetic shift.
  function automatic longint floorDivPow2(input longint v, input int s);
    longint p;
    p = longint'(1) << s;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  function automatic void refModel(input int idx, input logic [31:0] xi, input logic [31:0] yi,
                                   input logic [31:0] zi, output logic [31:0] ex,
                                   output logic [31:0] ey, output logic [31:0] ez);
    int     atanTab[16] = '{804, 474, 250, 127, 63, 31, 15, 7, 3, 1, 0, 0, 0, 0, 0, 0};
    longint xv, yv, zv, xsv, ysv, rx, ry, rz;
    xv  = longint'($signed(xi));
    yv  = longint'($signed(yi));
    zv  = longint'($signed(zi));
    xsv = floorDivPow2(xv, idx);
    ysv = floorDivPow2(yv, idx);
    if (zv >= 0) begin
      rx = xv - ysv;  ry = yv + xsv;  rz = zv - atanTab[idx];
    end else begin
      rx = xv + ysv;  ry = yv - xsv;  rz = zv + atanTab[idx];
    end
    ex = rx[31:0];
    ey = ry[31:0];
    ez = rz[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] xi, input logic [31:0] yi,
                               input logic [31:0] zi, input int tag);
    expect_t e;
    @(posedge clk);
    #1;
    i = 4'(idx);
    x = xi;
    y = yi;
    z = zi;
    refModel(idx, xi, yi, zi, e.ex, e.ey, e.ez);
    e.cycle = cyc + 1;
    e.tag   = tag;
    sbQueue.push_back(e);
  endtask

  // Monitor: pops the entry whose capture edge has just passed.
  always @(negedge clk) begin
    while (sbQueue.size() > 0 && sbQueue[0].cycle <= cyc) begin
      expect_t e;
      e = sbQueue.pop_front();
      if (e.cycle < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_missed tag=%0d: got=none want=cycle %0d", e.tag, e.cycle);
      end else begin
        checkOutput($sformatf("x_out tag=%0d", e.tag), x_out, e.ex);
        checkOutput($sformatf("y_out tag=%0d", e.tag), y_out, e.ey);
        checkOutput($sformatf("z_out tag=%0d", e.tag), z_out, e.ez);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ex, ey, ez;
    logic [31:0] rz;
    int          drain;

`ifdef CORDIC_SA_VALID_EN
    in_valid = 1'b1;
`endif
    rst_n = 1'b0;
    i = 4'd3;
    x = 32'd1234;
    y = 32'd567;
    z = 32'd89;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset x_out", x_out, 32'd0);
    checkOutput("reset y_out", y_out, 32'd0);
    checkOutput("reset z_out", z_out, 32'd0);
    rst_n = 1'b1;

    applyStimulus(0, 32'd1000, 32'd0, 32'd100, 1);
    applyStimulus(2, 32'd1000, 32'd400, -32'sd50, 2);
    applyStimulus(1, -32'sd7, 32'd5, 32'd0, 3);
    applyStimulus(12, 32'd4096, -32'sd4096, 32'd5, 4);
    applyStimulus(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    applyStimulus(15, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 6);

    for (int n = 0; n < 300; n++) begin
      rz = $urandom();
      if (n % 10 == 0) rz = 32'd0;
      else if (n % 3 == 0) rz = 32'($signed(16'($urandom())));
      applyStimulus($urandom_range(0, 15), $urandom(), $urandom(), rz, 100 + n);
    end

    drain = 0;
    while (sbQueue.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(negedge clk);
    total++;
    if (sbQueue.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drain: got=%0d pending want=0", sbQueue.size());
    end

    // Load a known nonzero result, then reset asynchronously between edges.
    @(posedge clk);
    #1;
    i = 4'd0;
    x = 32'd1000;
    y = 32'd0;
    z = 32'd100;
    @(posedge clk);
    #1;
    checkOutput("preload x_out", x_out, 32'd1000);
    checkOutput("preload y_out", y_out, 32'd1000);
    checkOutput("preload z_out", z_out, -32'sd704);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async x_out", x_out, 32'd0);
    checkOutput("async y_out", y_out, 32'd0);
    checkOutput("async z_out", z_out, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held x_out", x_out, 32'd0);
    checkOutput("held y_out", y_out, 32'd0);
    checkOutput("held z_out", z_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i = 4'd2;
    x = 32'd1000;
    y = 32'd400;
    z = -32'sd50;
    refModel(2, x, y, z, ex, ey, ez);
    @(posedge clk);
    #1;
    checkOutput("release x_out", x_out, ex);
    checkOutput("release y_out", y_out, ey);
    checkOutput("release z_out", z_out, ez);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
